master_spi: RTL

MASTER_SPI -- requirements
Module: master_spi

---
 rtl/master_spi_pkg.sv | 19 +
 rtl/master_spi_clk_div.sv | 30 +++
 rtl/master_spi.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/master_spi_pkg.sv
// Shared SPI master constants: word width and mode from the DATA_WIDTH, CPOL and CPHA defines.
// Each define falls back to its default (8, 0, 0) when the build does not provide it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CPOL
`define CPOL 0
`endif
`ifndef CPHA
`define CPHA 0
`endif

package master_spi_pkg;
  localparam int unsigned DataW    = `DATA_WIDTH;
  localparam int unsigned NumEdges = 2 * DataW;
  localparam int unsigned EdgeCntW = $clog2(NumEdges) + 1;
  localparam logic        CpolVal  = (`CPOL != 0);
  localparam logic        CphaVal  = (`CPHA != 0);
endpackage

// File: rtl/master_spi_clk_div.sv
// Half-period counter for the SPI master: one-cycle tick every CLK_DIV cycles while enabled.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_m,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int unsigned CntW = $clog2(CLK_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CntW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_m or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/master_spi.sv
// SPI master: IDLE -> SETUP -> XFER -> HOLD -> IDLE, MSB first, mode set by CPOL/CPHA.
// Define CONT_XFER_EN to chain words back to back with ss held low.
module master_spi
  import master_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk_m,
  input  logic             rst,
  input  logic             start,
  input  logic [DataW-1:0] data_in_master,
  input  logic             miso,
  output logic             sclk_m,
  output logic             ss,
  output logic             mosi,
  output logic [DataW-1:0] data_out_master,
  output logic             data_valid,
  output logic             busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [DataW-1:0]    tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
  logic [EdgeCntW-1:0] edge_q, edge_d;
  logic                sclk_q, sclk_d, mosi_q, mosi_d, dv_q, dv_d;
  logic                tick, load, odd_edge, final_edge, sample_now, shift_now;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk_m(clk_m),
    .rst  (rst),
    .en   (busy),
    .tick (tick)
  );

  // edge_q counts completed edges, so the edge about to happen is odd when edge_q is even.
  assign odd_edge   = ~edge_q[0];
  assign final_edge = (edge_q == EdgeCntW'(NumEdges - 1));
  assign sample_now = CphaVal ? ~odd_edge : odd_edge;
  assign shift_now  = CphaVal ? odd_edge : (~odd_edge && !final_edge);

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    dv_d    = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          edge_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          if (sample_now) begin
            rx_d = {rx_q[DataW-2:0], miso};
          end
          if (shift_now) begin
            mosi_d = tx_q[DataW-1];
            tx_d   = {tx_q[DataW-2:0], 1'b0};
          end
          if (final_edge) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          dout_d  = rx_q;
          dv_d    = 1'b1;
          state_d = IDLE;
`ifdef CONT_XFER_EN
          if (start) begin
            load    = 1'b1;
            state_d = SETUP;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // CPHA=0 presents the MSB during SETUP; CPHA=1 presents it on the first edge.
    if (load) begin
      rx_d = '0;
      if (CphaVal) begin
        tx_d   = data_in_master;
        mosi_d = 1'b0;
      end else begin
        tx_d   = {data_in_master[DataW-2:0], 1'b0};
        mosi_d = data_in_master[DataW-1];
      end
    end
  end

  always_ff @(posedge clk_m or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      edge_q  <= '0;
      sclk_q  <= CpolVal;
      mosi_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      dv_q    <= dv_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign ss              = (state_q == IDLE);
  assign mosi            = busy & mosi_q;
  assign sclk_m          = sclk_q;
  assign data_out_master = dout_q;
  assign data_valid      = dv_q;
endmodule
